count_enable_gen: RTL and testbench

Control stage directly upstream of the 4-bit `counter`: turns raw start/stop/burst/step push-button inputs into the `enable` strobe the counter consumes. Synchronises and debounces each button, runs a small mode FSM (idle, free-run, fixed-length burst), and paces the strobe with a prescaler so the counter advances once every PRESCALE clocks. Its `enable` output wires straight to the counter's `enable` port.

---
 rtl/count_enable_gen.sv | 178 +++++++++++++++++
 tb/tb_count_enable_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_enable_gen.sv
`timescale 1ns/1ps
// Button front end for the 4-bit counter: synchronise and debounce start/stop/burst(/step), then pace a one-cycle enable strobe.
// Optional feature: define COUNT_STEP_EN to build the single-step button path (btn_step acted on in IDLE).
module count_enable_gen #(
    parameter int PRESCALE  = 4,
    parameter int DEBOUNCE  = 3,
    parameter int BURST_LEN = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_start,
    input  logic btn_stop,
    input  logic btn_burst,
    input  logic btn_step,
    output logic enable,
    output logic running,
    output logic busy,
    output logic burst_done
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN + 1) : 1;
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int B_STOP  = 0;
    localparam int B_START = 1;
    localparam int B_BURST = 2;
`ifdef COUNT_STEP_EN
    localparam int B_STEP  = 3;
    localparam int NBTN    = 4;
`else
    localparam int NBTN    = 3;
`endif

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] evt;

    assign btn_raw[B_STOP]  = btn_stop;
    assign btn_raw[B_START] = btn_start;
    assign btn_raw[B_BURST] = btn_burst;
`ifdef COUNT_STEP_EN
    assign btn_raw[B_STEP]  = btn_step;
`else
    logic unused_step;
    assign unused_step = btn_step;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          deb_reg;
            logic          deb_d_reg;
            logic          evt_reg;
            logic [DW-1:0] cnt_reg;

            // Debounced level only moves after DEBOUNCE consecutive mismatching samples.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b0;
                    deb_d_reg <= 1'b0;
                    evt_reg   <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg != deb_reg) begin
                        if (cnt_reg == DW'(DEBOUNCE - 1)) begin
                            deb_reg <= sync2_reg;
                            cnt_reg <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                    deb_d_reg <= deb_reg;
                    evt_reg   <= deb_reg & ~deb_d_reg;
                end
            end

            assign evt[gi] = evt_reg;
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_BURST} state_t;

    state_t        state_reg;
    logic [PW-1:0] presc_reg;
    logic [BW-1:0] burst_cnt_reg;
    logic          enable_reg;
    logic          running_reg;
    logic          busy_reg;
    logic          burst_done_reg;
    logic          strobe;

    assign strobe = (presc_reg == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            presc_reg      <= '0;
            burst_cnt_reg  <= '0;
            enable_reg     <= 1'b0;
            running_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            burst_done_reg <= 1'b0;
        end else begin
            enable_reg     <= 1'b0;
            burst_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    presc_reg <= '0;
                    // A stop event in IDLE still outranks the others and swallows them.
                    if (!evt[B_STOP]) begin
                        if (evt[B_START]) begin
                            state_reg   <= ST_RUN;
                            running_reg <= 1'b1;
                            busy_reg    <= 1'b1;
                        end else if (evt[B_BURST]) begin
                            state_reg     <= ST_BURST;
                            busy_reg      <= 1'b1;
                            burst_cnt_reg <= BW'(BURST_LEN);
                        end
`ifdef COUNT_STEP_EN
                        else if (evt[B_STEP]) begin
                            enable_reg <= 1'b1;
                        end
`endif
                    end
                end
                ST_RUN: begin
                    if (evt[B_STOP]) begin
                        state_reg   <= ST_IDLE;
                        running_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                        presc_reg   <= '0;
                    end else begin
                        presc_reg  <= strobe ? '0 : presc_reg + 1'b1;
                        enable_reg <= strobe;
                    end
                end
                ST_BURST: begin
                    if (evt[B_STOP]) begin
                        state_reg     <= ST_IDLE;
                        busy_reg      <= 1'b0;
                        presc_reg     <= '0;
                        burst_cnt_reg <= '0;
                    end else if (burst_cnt_reg == '0) begin
                        state_reg      <= ST_IDLE;
                        busy_reg       <= 1'b0;
                        burst_done_reg <= 1'b1;
                        presc_reg      <= '0;
                    end else begin
                        presc_reg  <= strobe ? '0 : presc_reg + 1'b1;
                        enable_reg <= strobe;
                        if (strobe) begin
                            burst_cnt_reg <= burst_cnt_reg - 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    running_reg <= 1'b0;
                    busy_reg    <= 1'b0;
                    presc_reg   <= '0;
                end
            endcase
        end
    end

    assign enable     = enable_reg;
    assign running    = running_reg;
    assign busy       = busy_reg;
    assign burst_done = burst_done_reg;

endmodule

// File: tb/tb_count_enable_gen.sv
`timescale 1ns/1ps
// Directed bench for count_enable_gen: expected enable/burst_done cycles are queued at stimulus time and matched by a monitor.
module tb_count_enable_gen;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_start = 1'b0;
    logic btn_stop = 1'b0;
    logic btn_burst = 1'b0;
    logic btn_step = 1'b0;
    logic enable, running, busy, burst_done;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int en_q[$];
    int done_q[$];

`ifdef COUNT_STEP_EN
    localparam logic STEP_EXP = 1'b1;
`else
    localparam logic STEP_EXP = 1'b0;
`endif

    count_enable_gen #(.PRESCALE(4), .DEBOUNCE(3), .BURST_LEN(5)) dut (
        .clk(clk),
        .reset(reset),
        .btn_start(btn_start),
        .btn_stop(btn_stop),
        .btn_burst(btn_burst),
        .btn_step(btn_step),
        .enable(enable),
        .running(running),
        .busy(busy),
        .burst_done(burst_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic go(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: every enable / burst_done high cycle must match the queue head.
    always @(negedge clk) begin : mon
        logic exp_en;
        logic exp_done;
        exp_en   = (en_q.size() > 0) && (en_q[0] == cyc);
        exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
        if (exp_en) void'(en_q.pop_front());
        if (exp_done) void'(done_q.pop_front());
        if (exp_en || enable === 1'b1) begin
            check("enable_pulse", {31'd0, enable}, {31'd0, exp_en});
            $display("cyc %0d enable=%0b expected=%0b", cyc, enable, exp_en);
        end
        if (exp_done || burst_done === 1'b1) begin
            check("burst_done_pulse", {31'd0, burst_done}, {31'd0, exp_done});
            $display("cyc %0d burst_done=%0b expected=%0b", cyc, burst_done, exp_done);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        // Reset held with buttons toggling
        for (int i = 1; i <= 8; i++) begin
            go(i);
            {btn_start, btn_stop, btn_burst, btn_step} = 4'($urandom_range(0, 15));
            check("reset_outputs", {28'd0, enable, running, busy, burst_done}, 32'd0);
        end
        go(9);
        {btn_start, btn_stop, btn_burst, btn_step} = 4'b0000;
        go(10);
        reset = 1'b1;
        go(25);
        check("post_reset_idle", {28'd0, enable, running, busy, burst_done}, 32'd0);

        // Two-cycle glitch on start is rejected
        n = 30;
        go(n);
        btn_start = 1'b1;
        go(n + 2);
        btn_start = 1'b0;
        go(n + 10);
        check("glitch_running", {31'd0, running}, 32'd0);
        check("glitch_busy", {31'd0, busy}, 32'd0);

        // Run then stop; stop lands on a strobe edge and must suppress it
        n = 50;
        go(n);
        btn_start = 1'b1;
        for (int k = 0; k < 7; k++) en_q.push_back(n + 11 + 4 * k);
        go(n + 6);
        check("run_latency_before", {31'd0, running}, 32'd0);
        go(n + 7);
        check("run_running", {31'd0, running}, 32'd1);
        check("run_busy", {31'd0, busy}, 32'd1);
        go(n + 10);
        btn_start = 1'b0;
        go(n + 32);
        btn_stop = 1'b1;
        go(n + 38);
        check("stop_latency_before", {31'd0, running}, 32'd1);
        go(n + 39);
        check("stop_running", {31'd0, running}, 32'd0);
        check("stop_busy", {31'd0, busy}, 32'd0);
        check("stop_enable", {31'd0, enable}, 32'd0);
        go(n + 42);
        btn_stop = 1'b0;
        go(n + 60);

        // Burst of 5 with an ignored start press in the middle
        n = 120;
        go(n);
        btn_burst = 1'b1;
        for (int k = 0; k < 5; k++) en_q.push_back(n + 11 + 4 * k);
        done_q.push_back(n + 28);
        go(n + 7);
        check("burst_busy", {31'd0, busy}, 32'd1);
        check("burst_running", {31'd0, running}, 32'd0);
        go(n + 10);
        btn_burst = 1'b0;
        go(n + 12);
        btn_start = 1'b1;
        go(n + 20);
        check("burst_start_ignored", {30'd0, running, busy}, 32'd1);
        go(n + 22);
        btn_start = 1'b0;
        go(n + 27);
        check("burst_last_busy", {31'd0, busy}, 32'd1);
        go(n + 28);
        check("burst_end_busy", {31'd0, busy}, 32'd0);
        check("burst_end_done", {31'd0, burst_done}, 32'd1);
        go(n + 29);
        check("burst_done_one_cycle", {31'd0, burst_done}, 32'd0);
        go(n + 45);

        // Abort: stop and start together during a burst
        n = 170;
        go(n);
        btn_burst = 1'b1;
        for (int k = 0; k < 3; k++) en_q.push_back(n + 11 + 4 * k);
        go(n + 10);
        btn_burst = 1'b0;
        go(n + 14);
        btn_stop = 1'b1;
        btn_start = 1'b1;
        go(n + 20);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        go(n + 21);
        check("abort_idle", {30'd0, running, busy}, 32'd0);
        go(n + 24);
        btn_stop = 1'b0;
        btn_start = 1'b0;
        go(n + 30);
        check("abort_stays_idle", {30'd0, running, busy}, 32'd0);
        go(n + 40);

        // Reset mid-burst, with start held through reset release
        n = 215;
        go(n);
        btn_burst = 1'b1;
        en_q.push_back(n + 11);
        en_q.push_back(n + 15);
        go(n + 10);
        btn_burst = 1'b0;
        go(n + 17);
        reset = 1'b0;
        btn_start = 1'b1;
        #1;
        check("reset_midburst", {28'd0, enable, running, busy, burst_done}, 32'd0);
        go(n + 20);
        reset = 1'b1;
        r = n + 20;
        for (int k = 0; k < 4; k++) en_q.push_back(r + 11 + 4 * k);
        go(r + 6);
        check("held_start_before", {31'd0, running}, 32'd0);
        go(r + 7);
        check("held_start_running", {31'd0, running}, 32'd1);
        go(r + 14);
        btn_start = 1'b0;
        go(r + 20);
        btn_stop = 1'b1;
        go(r + 26);
        check("held_stop_before", {31'd0, running}, 32'd1);
        go(r + 27);
        check("held_stop_idle", {30'd0, running, busy}, 32'd0);
        go(r + 30);
        btn_stop = 1'b0;
        go(r + 45);

        // Single step in IDLE
        n = 290;
        go(n);
        btn_step = 1'b1;
        if (STEP_EXP) en_q.push_back(n + 7);
        go(n + 7);
        check("step_enable", {31'd0, enable}, {31'd0, STEP_EXP});
        check("step_busy", {31'd0, busy}, 32'd0);
        go(n + 8);
        check("step_enable_one_cycle", {31'd0, enable}, 32'd0);
        go(n + 10);
        btn_step = 1'b0;
        go(n + 30);

        check("enable_queue_drained", en_q.size(), 32'd0);
        check("done_queue_drained", done_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
